// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg
//   Shared types and constants for the SDRAM port arbiter.
//   - arb_state_t : arbiter FSM state encoding (3-bit).
//   - OWNER_CPU / OWNER_DMA : encoding of the last_owner flag.
//   - DMA_SEL : byte select driven to SDRAM while the DMA engine owns the port.
//   - BEAT_W : width of the burst beat counter (holds BURST_LEN up to 15).
//   - pick_owner() : round-robin decision for the IDLE state.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CPU       = 3'd1,
        ST_DMA       = 3'd2,
        ST_DMA_BURST = 3'd3,
        ST_RELEASE   = 3'd4
    } arb_state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_DMA = 1'b1;
    localparam logic [3:0] DMA_SEL   = 4'hF;
    localparam int         BEAT_W    = 4;

    // Only meaningful when at least one master requests. On a tie the
    // master that did not own the port last time wins.
    function automatic logic pick_owner(input logic cpu_req,
                                        input logic dma_req,
                                        input logic last_owner);
        if (cpu_req && dma_req) return ~last_owner;
        if (cpu_req)            return OWNER_CPU;
        return OWNER_DMA;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// wb_watchdog
//   Idle-cycle counter for a Wishbone transaction. Counts while enabled and
//   raises timeout_o on the cycle the count reaches TIMEOUT_CYC-1, unless a
//   clear arrives in that same cycle (progress beats the timeout).
//   Ports:
//     wb_clk_i   in   clock
//     wb_rst_i   in   asynchronous active-high reset
//     clr_i      in   restart the count from zero (state entry, ack, beat)
//     en_i       in   count this cycle (port owned)
//     timeout_o  out  watchdog expired this cycle
import sdram_arb_pkg::*;

module wb_watchdog #(
    parameter int TO_W        = 9,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_o
);

    localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= '0;
        end else if (en_i && (cnt != LAST)) begin
            // Saturate: the FSM leaves the owned state on expiry anyway.
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout_o = en_i & ~clr_i & (cnt == LAST);

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAM-controller Wishbone port between the CPU and the
//   DMA read engine. One owner per transaction, round-robin on contention,
//   DMA read bursts are never split, and a watchdog frees the port if the
//   SDRAM goes silent.
//   Ports:
//     wb_clk_i, wb_rst_i              clock, async active-high reset
//     cpu_cyc/stb/we/sel/adr/dat_i    CPU request
//     cpu_ack_o, cpu_err_o, cpu_dat_o CPU response (err = timeout pulse)
//     dma_cyc/stb/we/adr/fun_sel_i    DMA request
//     dma_ack_o, dma_burst_en_o,
//     dma_err_o, dma_dat_o            DMA response / burst beats
//     dram_*_o                        muxed request to SDRAM controller
//     dram_ack_i, dram_burst_en_i,
//     dram_dat_i                      SDRAM response
//     grant_o                         {dma_owns, cpu_owns}
//   All outputs are combinational muxes selected by the registered state.
import sdram_arb_pkg::*;

module sdram_port_arbiter #(
    parameter int BURST_LEN   = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int TO_W        = 9
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // CPU master
    input  logic        cpu_cyc_i,
    input  logic        cpu_stb_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_adr_i,
    input  logic [31:0] cpu_dat_i,
    output logic        cpu_ack_o,
    output logic        cpu_err_o,
    output logic [31:0] cpu_dat_o,
    // DMA master
    input  logic        dma_cyc_i,
    input  logic        dma_stb_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_adr_i,
    input  logic        dma_fun_sel_i,
    output logic        dma_ack_o,
    output logic        dma_burst_en_o,
    output logic        dma_err_o,
    output logic [31:0] dma_dat_o,
    // SDRAM controller port
    output logic        dram_cyc_o,
    output logic        dram_stb_o,
    output logic        dram_we_o,
    output logic [3:0]  dram_sel_o,
    output logic [31:0] dram_adr_o,
    output logic [31:0] dram_dat_o,
    output logic        dram_fun_sel_o,
    input  logic        dram_ack_i,
    input  logic        dram_burst_en_i,
    input  logic [31:0] dram_dat_i,
    // Status
    output logic [1:0]  grant_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state, state_nxt;
    logic              last_owner, last_owner_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;

    logic cpu_req, dma_req;
    logic owned, dma_owned;
    logic wd_clr, wd_timeout;
    logic owner_sel;

    assign cpu_req   = cpu_cyc_i & cpu_stb_i;
    assign dma_req   = dma_cyc_i & dma_stb_i;
    assign dma_owned = (state == ST_DMA) || (state == ST_DMA_BURST);
    assign owned     = (state == ST_CPU) || dma_owned;
    assign owner_sel = pick_owner(cpu_req, dma_req, last_owner);

    // Cleared outside owned states so every owned-state entry from IDLE
    // starts at zero; DMA -> DMA_BURST entry is always via an ack or beat.
    assign wd_clr = ~owned | dram_ack_i | (dma_owned & dram_burst_en_i);

    wb_watchdog #(
        .TO_W        (TO_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .clr_i     (wd_clr),
        .en_i      (owned),
        .timeout_o (wd_timeout)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_DMA;   // CPU wins the first tie
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first; a path that
    // forgets one would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        beat_cnt_nxt   = beat_cnt;
        cpu_ack_o      = 1'b0;
        cpu_err_o      = 1'b0;
        cpu_dat_o      = '0;
        dma_ack_o      = 1'b0;
        dma_burst_en_o = 1'b0;
        dma_err_o      = 1'b0;
        dma_dat_o      = '0;
        dram_cyc_o     = 1'b0;
        dram_stb_o     = 1'b0;
        dram_we_o      = 1'b0;
        dram_sel_o     = '0;
        dram_adr_o     = '0;
        dram_dat_o     = '0;
        dram_fun_sel_o = 1'b0;
        grant_o        = 2'b00;

        case (state)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    // Recording the owner at grant time is equivalent to doing
                    // it in RELEASE: only the next IDLE decision reads it.
                    last_owner_nxt = owner_sel;
                    state_nxt      = (owner_sel == OWNER_CPU) ? ST_CPU : ST_DMA;
                end
            end

            ST_CPU: begin
                grant_o    = 2'b01;
                dram_cyc_o = cpu_cyc_i;
                dram_stb_o = cpu_stb_i;
                dram_we_o  = cpu_we_i;
                dram_sel_o = cpu_sel_i;
                dram_adr_o = cpu_adr_i;
                dram_dat_o = cpu_dat_i;
                cpu_dat_o  = dram_dat_i;
                cpu_ack_o  = dram_ack_i;
                if (dram_ack_i) begin
                    state_nxt = ST_RELEASE;
                end else if (!cpu_cyc_i) begin
                    state_nxt = ST_RELEASE;           // abort, no error
                end else if (wd_timeout) begin
                    cpu_err_o = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end

            ST_DMA: begin
                grant_o        = 2'b10;
                dram_cyc_o     = dma_cyc_i;
                dram_stb_o     = dma_stb_i;
                dram_we_o      = dma_we_i;
                dram_sel_o     = DMA_SEL;
                dram_adr_o     = dma_adr_i;
                dram_fun_sel_o = dma_fun_sel_i;
                dma_dat_o      = dram_dat_i;
                dma_ack_o      = dram_ack_i;
                if (dram_ack_i && dma_we_i) begin
                    state_nxt = ST_RELEASE;
                end else if (dram_ack_i || dram_burst_en_i) begin
                    // A read ack opens the burst; a beat without a prior ack
                    // opens it too and is counted as the first beat.
                    if (dram_burst_en_i) begin
                        dma_burst_en_o = 1'b1;
                        if (LAST_BEAT == '0) begin
                            state_nxt = ST_RELEASE;
                        end else begin
                            beat_cnt_nxt = BEAT_W'(1);
                            state_nxt    = ST_DMA_BURST;
                        end
                    end else begin
                        beat_cnt_nxt = '0;
                        state_nxt    = ST_DMA_BURST;
                    end
                end else if (!dma_cyc_i) begin
                    state_nxt = ST_RELEASE;           // abort, no error
                end else if (wd_timeout) begin
                    dma_err_o = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end

            ST_DMA_BURST: begin
                // Bus cycle is over; SDRAM streams beats on its own. The DMA
                // request is ignored so the burst cannot be aborted.
                grant_o        = 2'b10;
                dram_we_o      = dma_we_i;
                dram_sel_o     = DMA_SEL;
                dram_adr_o     = dma_adr_i;
                dram_fun_sel_o = dma_fun_sel_i;
                dma_dat_o      = dram_dat_i;
                dma_burst_en_o = dram_burst_en_i;
                if (dram_burst_en_i) begin
                    if (beat_cnt == LAST_BEAT) begin
                        state_nxt = ST_RELEASE;
                    end else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                    end
                end else if (wd_timeout) begin
                    dma_err_o = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                state_nxt = ST_IDLE;                  // one dead cycle
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter
//   Directed bench with a scoreboard. Stimulus pushes expected grants and
//   expected per-master responses into queues; a negedge monitor pops and
//   compares whenever the DUT presents a grant, ack, beat or error.
`timescale 1ns/1ps

module tb_sdram_port_arbiter;

    typedef enum logic [1:0] {EV_ACK = 2'd0, EV_ERR = 2'd1, EV_BEAT = 2'd2} ev_kind_e;

    typedef struct packed {
        ev_kind_e    kind;
        logic [31:0] data;
    } ev_t;

    typedef struct packed {
        logic [1:0]  grant;
        logic [31:0] adr;
    } grant_t;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        cpu_cyc_i, cpu_stb_i, cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_adr_i, cpu_dat_i;
    logic        cpu_ack_o, cpu_err_o;
    logic [31:0] cpu_dat_o;
    logic        dma_cyc_i, dma_stb_i, dma_we_i, dma_fun_sel_i;
    logic [31:0] dma_adr_i;
    logic        dma_ack_o, dma_burst_en_o, dma_err_o;
    logic [31:0] dma_dat_o;
    logic        dram_cyc_o, dram_stb_o, dram_we_o, dram_fun_sel_o;
    logic [3:0]  dram_sel_o;
    logic [31:0] dram_adr_o, dram_dat_o;
    logic        dram_ack_i, dram_burst_en_i;
    logic [31:0] dram_dat_i;
    logic [1:0]  grant_o;

    int tests = 0;
    int fails = 0;

    ev_t    cpu_q[$];
    ev_t    dma_q[$];
    grant_t grant_q[$];
    logic [1:0] prev_grant = 2'b00;

    always #5 wb_clk_i = ~wb_clk_i;

    sdram_port_arbiter #(
        .BURST_LEN   (4),
        .TIMEOUT_CYC (256),
        .TO_W        (9)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .cpu_cyc_i       (cpu_cyc_i),
        .cpu_stb_i       (cpu_stb_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_adr_i       (cpu_adr_i),
        .cpu_dat_i       (cpu_dat_i),
        .cpu_ack_o       (cpu_ack_o),
        .cpu_err_o       (cpu_err_o),
        .cpu_dat_o       (cpu_dat_o),
        .dma_cyc_i       (dma_cyc_i),
        .dma_stb_i       (dma_stb_i),
        .dma_we_i        (dma_we_i),
        .dma_adr_i       (dma_adr_i),
        .dma_fun_sel_i   (dma_fun_sel_i),
        .dma_ack_o       (dma_ack_o),
        .dma_burst_en_o  (dma_burst_en_o),
        .dma_err_o       (dma_err_o),
        .dma_dat_o       (dma_dat_o),
        .dram_cyc_o      (dram_cyc_o),
        .dram_stb_o      (dram_stb_o),
        .dram_we_o       (dram_we_o),
        .dram_sel_o      (dram_sel_o),
        .dram_adr_o      (dram_adr_o),
        .dram_dat_o      (dram_dat_o),
        .dram_fun_sel_o  (dram_fun_sel_o),
        .dram_ack_i      (dram_ack_i),
        .dram_burst_en_i (dram_burst_en_i),
        .dram_dat_i      (dram_dat_i),
        .grant_o         (grant_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected output, value 0x%08h, nothing expected", name, act);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge wb_clk_i) begin
        ev_t    e;
        grant_t g;
        if (wb_rst_i) begin
            prev_grant = 2'b00;
        end else begin
            if (grant_o != 2'b00 && grant_o != prev_grant) begin
                if (grant_q.size() == 0) begin
                    unexpected("grant", 32'(grant_o));
                end else begin
                    g = grant_q.pop_front();
                    check("grant_owner", 32'(grant_o), 32'(g.grant));
                    check("grant_adr", dram_adr_o, g.adr);
                    check("grant_gap", 32'(prev_grant), 32'd0);
                end
            end
            prev_grant = grant_o;

            if (cpu_ack_o || cpu_err_o) begin
                if (cpu_q.size() == 0) begin
                    unexpected("cpu_resp", cpu_dat_o);
                end else begin
                    e = cpu_q.pop_front();
                    check("cpu_kind", 32'(cpu_ack_o ? EV_ACK : EV_ERR), 32'(e.kind));
                    if (cpu_ack_o) check("cpu_dat", cpu_dat_o, e.data);
                end
            end

            if (dma_ack_o || dma_burst_en_o || dma_err_o) begin
                if (dma_q.size() == 0) begin
                    unexpected("dma_resp", dma_dat_o);
                end else begin
                    e = dma_q.pop_front();
                    check("dma_kind",
                          32'(dma_ack_o ? EV_ACK : (dma_burst_en_o ? EV_BEAT : EV_ERR)),
                          32'(e.kind));
                    if (!dma_err_o) check("dma_dat", dma_dat_o, e.data);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wait_grant(input string name, input logic [1:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (grant_o == exp) break;
        end
        check(name, 32'(grant_o), 32'(exp));
    endtask

    // Ack the current CPU cycle, then drop the CPU request (state -> RELEASE).
    task automatic cpu_ack(input logic [31:0] data);
        dram_ack_i = 1'b1;
        dram_dat_i = data;
        cpu_q.push_back('{kind: EV_ACK, data: data});
        tick();
        dram_ack_i = 1'b0;
        cpu_cyc_i  = 1'b0;
        cpu_stb_i  = 1'b0;
    endtask

    task automatic dma_beat(input logic [31:0] data);
        dram_burst_en_i = 1'b1;
        dram_dat_i      = data;
        dma_q.push_back('{kind: EV_BEAT, data: data});
        tick();
        dram_burst_en_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        wb_rst_i        = 1'b1;
        cpu_cyc_i       = 1'b1;
        cpu_stb_i       = 1'b1;
        cpu_we_i        = 1'b1;
        cpu_sel_i       = 4'h3;
        cpu_adr_i       = 32'h3000_0010;
        cpu_dat_i       = 32'h1234_5678;
        dma_cyc_i       = 1'b1;
        dma_stb_i       = 1'b1;
        dma_we_i        = 1'b0;
        dma_adr_i       = 32'h3800_0100;
        dma_fun_sel_i   = 1'b0;
        dram_ack_i      = 1'b0;
        dram_burst_en_i = 1'b0;
        dram_dat_i      = '0;

        // 1. reset with both requesting; CPU wins first
        repeat (3) tick();
        check("t1_rst_grant", 32'(grant_o), 32'd0);
        check("t1_rst_cyc", 32'(dram_cyc_o), 32'd0);
        grant_q.push_back('{grant: 2'b01, adr: 32'h3000_0010});
        wb_rst_i = 1'b0;
        tick();
        check("t1_grant_cpu", 32'(grant_o), 32'd1);
        check("t1_adr", dram_adr_o, 32'h3000_0010);
        check("t1_we", 32'(dram_we_o), 32'd1);
        check("t1_sel", 32'(dram_sel_o), 32'h3);
        check("t1_dat", dram_dat_o, 32'h1234_5678);
        dma_cyc_i = 1'b0;
        dma_stb_i = 1'b0;

        // 2. CPU write acked on its third cycle, then RELEASE, then IDLE
        tick();
        tick();
        cpu_ack(32'h0BAD_F00D);
        check("t2_release_cyc", 32'(dram_cyc_o), 32'd0);
        check("t2_release_grant", 32'(grant_o), 32'd0);
        check("t2_ack_pulse", 32'(cpu_ack_o), 32'd0);
        tick();
        check("t2_idle_grant", 32'(grant_o), 32'd0);

        // 3. DMA read burst, CPU request arrives and waits
        dma_cyc_i     = 1'b1;
        dma_stb_i     = 1'b1;
        dma_we_i      = 1'b0;
        dma_adr_i     = 32'h3800_0200;
        dma_fun_sel_i = 1'b1;
        grant_q.push_back('{grant: 2'b10, adr: 32'h3800_0200});
        grant_q.push_back('{grant: 2'b01, adr: 32'h3000_0020});
        tick();
        cpu_cyc_i = 1'b1;
        cpu_stb_i = 1'b1;
        cpu_we_i  = 1'b0;
        cpu_adr_i = 32'h3000_0020;
        check("t3_dma_sel", 32'(dram_sel_o), 32'hF);
        check("t3_dma_dat", dram_dat_o, 32'd0);
        check("t3_fun_sel", 32'(dram_fun_sel_o), 32'd1);
        check("t3_dma_stb", 32'(dram_stb_o), 32'd1);
        tick();
        dram_ack_i = 1'b1;
        dram_dat_i = 32'hDEAD_0000;
        dma_q.push_back('{kind: EV_ACK, data: 32'hDEAD_0000});
        tick();
        dram_ack_i = 1'b0;
        dma_cyc_i  = 1'b0;
        dma_stb_i  = 1'b0;
        check("t3_burst_cyc", 32'(dram_cyc_o), 32'd0);
        check("t3_burst_stb", 32'(dram_stb_o), 32'd0);
        check("t3_burst_grant", 32'(grant_o), 32'd2);
        for (int i = 0; i < 4; i++) begin
            if (i == 2) tick();                   // idle gap inside the burst
            dma_beat(32'hA0 + 32'(i));
        end
        check("t3_release_grant", 32'(grant_o), 32'd0);
        wait_grant("t3_cpu_after", 2'b01, 10);
        cpu_ack(32'h5555_AAAA);
        tick();

        // 4. both request continuously: DMA, CPU, DMA, CPU
        cpu_cyc_i = 1'b1;
        cpu_stb_i = 1'b1;
        cpu_adr_i = 32'h3000_0030;
        dma_cyc_i = 1'b1;
        dma_stb_i = 1'b1;
        dma_we_i  = 1'b1;
        dma_adr_i = 32'h3800_0400;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b10 : 2'b01;
            grant_q.push_back('{grant: g, adr: (g == 2'b10) ? 32'h3800_0400 : 32'h3000_0030});
            wait_grant("t4_grant", g, 10);
            dram_ack_i = 1'b1;
            dram_dat_i = 32'h4000_0000 + 32'(k);
            if (g == 2'b10) dma_q.push_back('{kind: EV_ACK, data: dram_dat_i});
            else            cpu_q.push_back('{kind: EV_ACK, data: dram_dat_i});
            tick();
            dram_ack_i = 1'b0;
            check("t4_release", 32'(grant_o), 32'd0);
        end
        cpu_cyc_i = 1'b0;
        cpu_stb_i = 1'b0;
        dma_cyc_i = 1'b0;
        dma_stb_i = 1'b0;
        tick();

        // 5. DMA read with silent SDRAM: error on cycle 256, then CPU
        dma_we_i  = 1'b0;
        dma_adr_i = 32'h3800_0500;
        dma_cyc_i = 1'b1;
        dma_stb_i = 1'b1;
        cpu_adr_i = 32'h3000_0050;
        cpu_cyc_i = 1'b1;
        cpu_stb_i = 1'b1;
        grant_q.push_back('{grant: 2'b10, adr: 32'h3800_0500});
        grant_q.push_back('{grant: 2'b01, adr: 32'h3000_0050});
        wait_grant("t5_dma_grant", 2'b10, 10);
        repeat (255) tick();
        dma_q.push_back('{kind: EV_ERR, data: 32'd0});
        check("t5_err", 32'(dma_err_o), 32'd1);
        check("t5_err_grant", 32'(grant_o), 32'd2);
        tick();
        dma_cyc_i = 1'b0;
        dma_stb_i = 1'b0;
        check("t5_release", 32'(grant_o), 32'd0);
        check("t5_err_pulse", 32'(dma_err_o), 32'd0);
        wait_grant("t5_cpu_after", 2'b01, 10);
        cpu_ack(32'h0000_CAFE);
        tick();

        // 6. reset mid-burst, then a full burst afterwards
        dma_adr_i = 32'h3800_0600;
        dma_cyc_i = 1'b1;
        dma_stb_i = 1'b1;
        grant_q.push_back('{grant: 2'b10, adr: 32'h3800_0600});
        wait_grant("t6_grant", 2'b10, 10);
        dram_ack_i = 1'b1;
        dram_dat_i = 32'h6000_0000;
        dma_q.push_back('{kind: EV_ACK, data: 32'h6000_0000});
        tick();
        dram_ack_i = 1'b0;
        dma_cyc_i  = 1'b0;
        dma_stb_i  = 1'b0;
        dma_beat(32'hA0);
        dma_beat(32'hA1);
        dram_burst_en_i = 1'b1;
        dram_dat_i      = 32'hA2;
        #1 wb_rst_i = 1'b1;
        #1;
        check("t6_rst_grant", 32'(grant_o), 32'd0);
        check("t6_rst_beat", 32'(dma_burst_en_o), 32'd0);
        check("t6_rst_dat", dma_dat_o, 32'd0);
        check("t6_rst_adr", dram_adr_o, 32'd0);
        check("t6_rst_sel", 32'(dram_sel_o), 32'd0);
        dram_burst_en_i = 1'b0;
        tick();
        tick();
        wb_rst_i  = 1'b0;
        dma_adr_i = 32'h3800_0700;
        dma_cyc_i = 1'b1;
        dma_stb_i = 1'b1;
        grant_q.push_back('{grant: 2'b10, adr: 32'h3800_0700});
        wait_grant("t6_regrant", 2'b10, 10);
        dram_ack_i = 1'b1;
        dram_dat_i = 32'h7000_0000;
        dma_q.push_back('{kind: EV_ACK, data: 32'h7000_0000});
        tick();
        dram_ack_i = 1'b0;
        dma_cyc_i  = 1'b0;
        dma_stb_i  = 1'b0;
        for (int i = 0; i < 4; i++) dma_beat(32'hB0 + 32'(i));
        check("t6_release", 32'(grant_o), 32'd0);
        tick();
        check("t6_idle", 32'(grant_o), 32'd0);
        tick();

        check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
        check("dma_q_empty", 32'(dma_q.size()), 32'd0);
        check("grant_q_empty", 32'(grant_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
